// File: rtl/logic_accumulator_pkg.sv
// Shared operator encodings, FSM state type and fold identity for logic_accumulator.
package logic_accumulator_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  localparam int unsigned IDENT_W = 1024;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  // Returns the fold seed for the first `width` bits; callers size-cast to their width.
  function automatic logic [IDENT_W-1:0] identity(input logic [1:0] op, input int unsigned width);
    logic [IDENT_W-1:0] r;
    r = '0;
    if (op == OP_AND || op == OP_NAND) begin
      for (int unsigned i = 0; i < IDENT_W; i++) begin
        if (i < width) r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/logic_accumulator_bitwise_op.sv
// Combinational two-operand bitwise operator used for one fold step.
module bitwise_op
  import logic_accumulator_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y
);

  // NAND folds as AND; the inversion is applied once on the final result.
  always_comb begin
    y = a & b;
    case (op)
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = a & b;
    endcase
  end

endmodule

// File: rtl/logic_accumulator.sv
// Multi-cycle bitwise reduction of a burst of words, result on a valid/ready port.
//   state | meaning
//   IDLE  | waiting for start, no handshakes
//   ACCUM | accepting burst words, one per cycle
//   DONE  | result held on out_data until out_ready
module logic_accumulator
  import logic_accumulator_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int MAX_LEN = 16,
  localparam int CW      = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CW-1:0]    len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  state_t           state;
  logic [1:0]       op_q;
  logic [CW-1:0]    len_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] fin;
  logic [WIDTH-1:0] ident;
  logic [WIDTH-1:0] out_q;
  logic [CW-1:0]    len_eff;
  logic             beat;
  logic             last;

  bitwise_op #(.WIDTH(WIDTH)) u_op (
    .a  (acc_q),
    .b  (in_data),
    .op (op_q),
    .y  (acc_nxt)
  );

  assign ident   = WIDTH'(identity(op, WIDTH));
  assign len_eff = (len > CW'(MAX_LEN)) ? CW'(MAX_LEN) : len;
  assign beat    = in_valid & in_ready;
  assign last    = beat && (cnt_q == len_q - CW'(1));
  assign fin     = (op_q == OP_NAND) ? ~acc_nxt : acc_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op_q  <= '0;
      len_q <= '0;
      cnt_q <= '0;
      acc_q <= '0;
      out_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            len_q <= len_eff;
            cnt_q <= '0;
            acc_q <= ident;
            if (len_eff == '0) begin
              out_q <= (op == OP_NAND) ? ~ident : ident;
              state <= DONE;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (beat) begin
            acc_q <= acc_nxt;
            cnt_q <= cnt_q + CW'(1);
            if (last) begin
              out_q <= fin;
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_q <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = out_q;

endmodule
